fetch_sequencer: RTL
====================

# fetch_sequencer

Sequences instruction fetch for the single-cycle core against an instruction memory with a variable-latency request/acknowledge interface. Owns the architectural fetch PC (ADDRESS_BITS wide, byte-addressed, word-aligned) and issues one memory request at a time. Holds each returned instruction until decode accepts it, and applies branch/jump redirects from execute, including discarding a response that was already in flight. Sits between the execute stage's redirect outputs, decode's stall input and the instruction memory port.

## Interface
- ADDRESS_BITS, 16, PC and memory address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset (bits [1:0] ignored)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  one-cycle redirect request from execute
- redirect_PC  in  ADDRESS_BITS  redirect target; bits [1:0] forced to 0
- stall  in  1  decode cannot accept the held instruction this cycle
- imem_req  out  1  memory request outstanding
- imem_addr  out  ADDRESS_BITS  request address, stable while imem_req=1
- imem_ack  in  1  response valid; ignored when imem_req=0
- imem_rdata  in  DATA_WIDTH  response data, sampled when imem_req&imem_ack
- instr_valid  out  1  instr/instr_PC hold a valid instruction
- instr  out  DATA_WIDTH  held instruction
- instr_PC  out  ADDRESS_BITS  address of held instruction

## Operation
- State machine with states IDLE, REQ, HOLD and FLUSH. Internal registers: PC and req_addr (drives imem_addr).
- IDLE: imem_req=0. Next cycle moves to REQ with req_addr<=PC.
- REQ: imem_req=1.
  - On ack: instr<=imem_rdata, instr_PC<=req_addr, instr_valid<=1, PC<=req_addr+4, then HOLD.
  - Without ack: stay in REQ.
- HOLD: instr_valid=1, imem_req=0.
  - A cycle with instr_valid&!stall consumes the instruction: instr_valid<=0, req_addr<=PC, then REQ.
  - With stall=1: hold all outputs.
- FLUSH: imem_req=1 with the old req_addr until ack. On ack, rdata is discarded, req_addr<=PC, then REQ.
- Redirect has top priority in every state:
  - IDLE or HOLD: PC<=redirect_PC, req_addr<=redirect_PC, instr_valid<=0 (held instruction discarded even if stall=0), then REQ.
  - REQ without ack: PC<=redirect_PC, then FLUSH.
  - REQ with ack in the same cycle: rdata discarded, req_addr<=redirect_PC, PC<=redirect_PC, then REQ.
  - FLUSH: PC<=redirect_PC (latest redirect wins). On an ack in the same cycle, go to REQ with req_addr<=redirect_PC.
- Arithmetic: PC+4 is modulo 2^ADDRESS_BITS, so 0xFFFC wraps to 0x0000.
- Reset: PC=RESET_PC&~3, req_addr=0, state IDLE, imem_req=0, instr_valid=0, instr=0, instr_PC=0.
  - A request in flight is abandoned, and the memory must tolerate this.

## Timing
- imem_req is a registered output. Once high, it and imem_addr stay stable until the ack cycle inclusive.
- Minimum latency is reset deassert to first instr_valid = 3 cycles with a zero-wait memory (IDLE, REQ with ack, HOLD).
- Peak throughput is one instruction per 2 cycles. Each added memory wait state adds 1 cycle.
- instr_valid drops the cycle after consume or redirect.
- The cycle after an ack-in-REQ redirect has imem_req=1 with the new address.

## Configuration
- FETCH_PERF_CNT_EN defined adds two outputs:
  - fetch_count out 16: increments on each consume.
  - flush_count out 16: increments on each discarded response or discarded held instruction.
  - Both wrap at 0xFFFF→0 and reset to 0.
- Without the macro, these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset release with RESET_PC=0, zero-wait memory, stall=0 -> instr_PC sequence 0000, 0004, 0008 on alternate cycles, first instr_valid 3 cycles after reset drops.
- stall=1 for 4 cycles while instr_PC=0004 -> instr, instr_PC and instr_valid unchanged, imem_req=0, next request addr 0008 after stall drops.
- Memory with 3 wait states, redirect to 0x0040 in the first REQ cycle -> imem_addr held at the old address until ack, that rdata never appears, next imem_addr=0040, then instr_PC=0040. With FETCH_PERF_CNT_EN, flush_count=1.
- Redirect to 0x0010 in the same cycle as ack -> response discarded, next cycle imem_req=1 with imem_addr=0010.
- Redirect to 0xFFFC, consume twice -> instr_PC FFFC then 0000.
- Assert reset while in FLUSH -> next cycle imem_req=0, instr_valid=0, PC=RESET_PC. Normal fetch resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch with hold-until-decode and redirect flush.
// Optional FETCH_PERF_CNT_EN adds fetch_count / flush_count outputs.
module fetch_sequencer #(
  parameter int                      ADDRESS_BITS = 16,
  parameter int                      DATA_WIDTH   = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_PC,
  input  logic                    stall,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ack,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    instr_valid,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic [ADDRESS_BITS-1:0] instr_PC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]             fetch_count,
  output logic [15:0]             flush_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

  localparam logic [ADDRESS_BITS-1:0] WORD_MASK = {{(ADDRESS_BITS-2){1'b1}}, 2'b00};

  state_t                  state, state_nxt;
  logic [ADDRESS_BITS-1:0] pc, pc_nxt;
  logic [ADDRESS_BITS-1:0] req_addr, req_addr_nxt;
  logic [ADDRESS_BITS-1:0] tgt;
  logic                    accept, clr_valid, consume, discard;

  assign tgt       = redirect_PC & WORD_MASK;
  assign imem_addr = req_addr;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    accept       = 1'b0;
    clr_valid    = 1'b0;
    consume      = 1'b0;
    discard      = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_valid) begin
          pc_nxt       = tgt;
          req_addr_nxt = tgt;
          clr_valid    = 1'b1;
        end else begin
          req_addr_nxt = pc;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_nxt = tgt;
          if (imem_ack) begin
            // response lands on a dead path: drop it and re-request at once
            discard      = 1'b1;
            req_addr_nxt = tgt;
            state_nxt    = REQ;
          end else begin
            state_nxt = FLUSH;
          end
        end else if (imem_ack) begin
          accept    = 1'b1;
          pc_nxt    = req_addr + ADDRESS_BITS'(4);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt       = tgt;
          req_addr_nxt = tgt;
          clr_valid    = 1'b1;
          discard      = 1'b1;
          state_nxt    = REQ;
        end else if (!stall) begin
          consume      = 1'b1;
          clr_valid    = 1'b1;
          req_addr_nxt = pc;
          state_nxt    = REQ;
        end
      end
      FLUSH: begin
        // old request must complete before the bus can carry a new address
        if (redirect_valid) pc_nxt = tgt;
        if (imem_ack) begin
          discard      = 1'b1;
          req_addr_nxt = redirect_valid ? tgt : pc;
          state_nxt    = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC & WORD_MASK;
      req_addr    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_PC    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      imem_req <= (state_nxt == REQ) || (state_nxt == FLUSH);
      if (accept) begin
        instr       <= imem_rdata;
        instr_PC    <= req_addr;
        instr_valid <= 1'b1;
      end else if (clr_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (consume) fetch_count <= fetch_count + 16'd1;
      if (discard) flush_count <= flush_count + 16'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = consume ^ discard;
`endif

endmodule
